recv_sched: RTL
===============

# recv_sched

Shot scheduler for the echo-capture path. Issues one `send_en` strobe per angular shot at a programmable period, drives the capture delay and laser gate, and waits for the capture-complete strobe (`tola_en`) before the next shot. Indexes shots within one mirror revolution, starting from the encoder zero pulse. Sits between the scan/motor control and the 400-bit echo capture block.

## Interface
- `PER_W`, 16: width of shot period.
- `IDX_W`, 12: width of shot index and shots-per-rev.
- `TIMEOUT_CYC`, 64: echo watchdog margin beyond the delay, in clocks.
- `MIN_PERIOD`, 32: floor applied to the shot period.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `scan_start` in 1: level; scanning enabled.
- `zero_pulse` in 1: 1-cycle encoder index pulse.
- `laser_on` in 1: safety permit for emission.
- `shot_period` in PER_W: clocks between shot starts.
- `shots_per_rev` in IDX_W: shots per revolution, 0 treated as 1.
- `delay_cfg` in 8: capture delay forwarded to capture block.
- `tola_en` in 1: capture-complete strobe from capture block.
- `send_en` out 1: 1-cycle shot strobe.
- `delay_cnt` out 8: latched delay for capture block.
- `laser_enable` out 1: emission gate.
- `shot_idx` out IDX_W: index of the shot being reported.
- `shot_valid` out 1: 1-cycle shot result strobe.
- `shot_skip` out 1: qualifies `shot_valid`; shot not fired (laser_on low).
- `shot_err` out 1: qualifies `shot_valid`; echo timeout.
- `rev_done` out 1: 1-cycle end-of-revolution strobe.
- `rev_short` out 1: qualifies `rev_done`; revolution cut by early zero pulse.
- `missed_cnt` out 8: saturating timeout count, cleared at each revolution start.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, ARM, FIRE, WAIT_ECHO, GAP.
- IDLE → ARM when `scan_start`=1.
- ARM: wait for `zero_pulse`. On it, latch `shot_period` (clamped to ≥ MIN_PERIOD), `shots_per_rev`, and `delay_cfg`→`delay_cnt`. Set `shot_idx`=0, clear `missed_cnt`, go to FIRE.
- FIRE, one cycle, with period counter cleared to 0:
  - If `laser_on`=1: `send_en`=1 and go to WAIT_ECHO.
  - Otherwise: no strobe, `shot_valid`=1 with `shot_skip`=1, go to GAP.
- WAIT_ECHO: `laser_enable`=1.
  - On `tola_en`: `shot_valid`=1 next cycle, go to GAP.
- GAP: the next shot starts when the period counter reaches `shot_period`−1, or immediately if the echo ended later than that. Then:
  - If `shot_idx`=`shots_per_rev`−1: `rev_done`=1 and go to ARM, unless a zero pulse is pending; a pending pulse goes straight to the new-revolution latch.
  - Otherwise: `shot_idx`+1, go to FIRE.
- A `zero_pulse` in FIRE, WAIT_ECHO or GAP sets a pending flag. At the next GAP exit: `rev_done`=1, `rev_short`=1, re-latch config, `shot_idx`=0, go to FIRE. An in-flight echo is never abandoned.
- `scan_start` drop: the current WAIT_ECHO completes, then IDLE. From ARM, FIRE or GAP go to IDLE next cycle. No `rev_done` is issued.
- `laser_enable` is 0 outside WAIT_ECHO. `send_en` is never issued while `laser_on`=0, so the capture block cannot stall waiting on the gate.
- `tola_en` outside WAIT_ECHO is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; `delay_cnt`=0.
- `scan_start` to ARM: 1 cycle.
- `zero_pulse` to `send_en`: 2 cycles.
- `tola_en` to `shot_valid`: 1 cycle.
- Shot-to-shot spacing: exactly `shot_period` clocks when echo latency < period; otherwise echo latency + 2.
- Period counter is PER_W wide and never wraps (stops at the terminal value).
- Reset mid-shot: immediate return to IDLE; the capture block is reset by the same `rst`.

## Configuration
- `RECV_SCHED_TIMEOUT_EN` defined: WAIT_ECHO aborts after `delay_cnt`+TIMEOUT_CYC clocks without `tola_en`. On abort: `shot_valid`=1, `shot_err`=1, `missed_cnt` +1 (saturates at 255), go to GAP.
- Macro undefined: WAIT_ECHO waits indefinitely; `shot_err` and `missed_cnt` are tied to 0.

## Structure
- Shared package `scan_pkg`: state encodings, MIN_PERIOD, TIMEOUT_CYC defaults.
- One sub-module: `shot_timer`. It holds the period counter and the timeout counter, with clear, terminal, and expiry outputs.
- The FSM stays in `recv_sched`.

## Test plan
- shot_period=100, shots_per_rev=4, delay_cfg=1, tola_en 30 clocks after each send_en, laser_on=1 → 4 send_en at 100-clock spacing; shot_valid with idx 0..3; one rev_done, rev_short=0.
- shot_period=10 → clamped: send_en spacing = 32 clocks.
- laser_on=0 during shot 2 → no send_en at shot 2; shot_valid with shot_skip=1, idx=2; spacing preserved.
- zero_pulse at shot 1 of 4 (mid-WAIT_ECHO) → echo completes; rev_done with rev_short=1; next send_en has idx 0.
- `RECV_SCHED_TIMEOUT_EN`, delay_cfg=5, no tola_en → shot_err at 69 clocks after send_en; missed_cnt=1.
- scan_start drop in WAIT_ECHO, then rst low mid-GAP → IDLE after the echo; all outputs 0 on reset.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared scan-path definitions: shot-scheduler state encoding and default
// shot-timing constants.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    FIRE      = 3'd2,
    WAIT_ECHO = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam int MIN_PERIOD_DEF  = 32;
  localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/shot_timer.sv
// Period and echo-timeout counters for recv_sched. Both restart at 0 on
// clear and hold at their terminal value instead of wrapping.
module shot_timer #(
  parameter int PER_W = 16,
  parameter int TO_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             to_run,
  input  logic [PER_W-1:0] period,
  input  logic [TO_W-1:0]  to_limit,
  output logic             per_term,
  output logic             to_expire
);

  logic [PER_W-1:0] per_cnt;
  logic [TO_W-1:0]  to_cnt;

  assign per_term  = (per_cnt == period - PER_W'(1));
  assign to_expire = (to_cnt == to_limit - TO_W'(1));

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt <= '0;
      to_cnt  <= '0;
    end else if (clear) begin
      per_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (!per_term)            per_cnt <= per_cnt + PER_W'(1);
      if (to_run && !to_expire) to_cnt  <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/recv_sched.sv
// Shot scheduler for the echo-capture path. Define RECV_SCHED_TIMEOUT_EN to
// enable the echo watchdog (shot_err / missed_cnt); otherwise echoes wait forever.
module recv_sched
  import scan_pkg::*;
#(
  parameter int PER_W       = 16,
  parameter int IDX_W       = 12,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MIN_PERIOD  = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_start,
  input  logic             zero_pulse,
  input  logic             laser_on,
  input  logic [PER_W-1:0] shot_period,
  input  logic [IDX_W-1:0] shots_per_rev,
  input  logic [7:0]       delay_cfg,
  input  logic             tola_en,
  output logic             send_en,
  output logic [7:0]       delay_cnt,
  output logic             laser_enable,
  output logic [IDX_W-1:0] shot_idx,
  output logic             shot_valid,
  output logic             shot_skip,
  output logic             shot_err,
  output logic             rev_done,
  output logic             rev_short,
  output logic [7:0]       missed_cnt,
  output logic             busy
);

  localparam int TO_W = $clog2(256 + TIMEOUT_CYC);

  state_t           state, state_nxt;
  logic             zp_q, pend;
  logic [PER_W-1:0] period_q;
  logic [IDX_W-1:0] spr_q;
  logic             per_term, to_expire, timeout;
  logic             latch_cfg, adv_idx, rev_end, rev_cut, skip_shot, echo_ok, echo_to;
  logic             last_shot;

  // The zero pulse is registered once; that flop is the extra cycle of zero_pulse->send_en.
  assign last_shot    = (shot_idx == spr_q - IDX_W'(1));
  assign send_en      = (state == FIRE) && scan_start && laser_on;
  assign laser_enable = (state == WAIT_ECHO);
  assign busy         = (state != IDLE);

`ifdef RECV_SCHED_TIMEOUT_EN
  assign timeout = to_expire;
`else
  logic unused_to_expire;
  assign unused_to_expire = to_expire;
  assign timeout          = 1'b0;
`endif

  shot_timer #(.PER_W(PER_W), .TO_W(TO_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_nxt == FIRE),
    .to_run    ((state == FIRE) || (state == WAIT_ECHO)),
    .period    (period_q),
    .to_limit  (TO_W'(delay_cnt) + TO_W'(TIMEOUT_CYC)),
    .per_term  (per_term),
    .to_expire (to_expire)
  );

  // NOTE: every signal of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    latch_cfg = 1'b0;
    adv_idx   = 1'b0;
    rev_end   = 1'b0;
    rev_cut   = 1'b0;
    skip_shot = 1'b0;
    echo_ok   = 1'b0;
    echo_to   = 1'b0;
    case (state)
      IDLE: if (scan_start) state_nxt = ARM;
      ARM: begin
        if (!scan_start) state_nxt = IDLE;
        else if (zp_q) begin
          latch_cfg = 1'b1;
          state_nxt = FIRE;
        end
      end
      FIRE: begin
        if (!scan_start)   state_nxt = IDLE;
        else if (laser_on) state_nxt = WAIT_ECHO;
        else begin
          skip_shot = 1'b1;
          state_nxt = GAP;
        end
      end
      WAIT_ECHO: begin
        // An echo in flight always completes, even if scanning was dropped.
        if (tola_en) begin
          echo_ok   = 1'b1;
          state_nxt = scan_start ? GAP : IDLE;
        end else if (timeout) begin
          echo_to   = 1'b1;
          state_nxt = scan_start ? GAP : IDLE;
        end
      end
      GAP: begin
        if (!scan_start) state_nxt = IDLE;
        else if (per_term) begin
          if (pend || zp_q) begin
            rev_end   = 1'b1;
            rev_cut   = !last_shot;
            latch_cfg = 1'b1;
            state_nxt = FIRE;
          end else if (last_shot) begin
            rev_end   = 1'b1;
            state_nxt = ARM;
          end else begin
            adv_idx   = 1'b1;
            state_nxt = FIRE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the latched configuration is reset as well, so delay_cnt reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      zp_q       <= 1'b0;
      pend       <= 1'b0;
      period_q   <= PER_W'(MIN_PERIOD);
      spr_q      <= IDX_W'(1);
      delay_cnt  <= '0;
      shot_idx   <= '0;
      shot_valid <= 1'b0;
      shot_skip  <= 1'b0;
      shot_err   <= 1'b0;
      rev_done   <= 1'b0;
      rev_short  <= 1'b0;
      missed_cnt <= '0;
    end else begin
      state      <= state_nxt;
      zp_q       <= zero_pulse;
      shot_valid <= skip_shot || echo_ok || echo_to;
      shot_skip  <= skip_shot;
      shot_err   <= echo_to;
      rev_done   <= rev_end;
      rev_short  <= rev_cut;

      if (latch_cfg || state == IDLE || state == ARM) pend <= 1'b0;
      else if (zp_q)                                  pend <= 1'b1;

      if (latch_cfg) begin
        period_q  <= (shot_period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : shot_period;
        spr_q     <= (shots_per_rev == '0) ? IDX_W'(1) : shots_per_rev;
        delay_cnt <= delay_cfg;
        shot_idx  <= '0;
      end else if (adv_idx) begin
        shot_idx  <= shot_idx + IDX_W'(1);
      end

      if (latch_cfg)                           missed_cnt <= '0;
      else if (echo_to && missed_cnt != 8'hFF) missed_cnt <= missed_cnt + 8'd1;
    end
  end

endmodule
